// File: rtl/mcpu_avl_pkg.sv
// Shared Avalon-MM widths and FSM state type for the BRAM stand-in
// that serves the ltc2mc memory port.
package mcpu_avl_pkg;

    localparam int AVL_ADDR_W = 25;
    localparam int AVL_DATA_W = 128;
    localparam int AVL_BE_W   = 16;
    localparam int AVL_SIZE_W = 5;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        WR_BURST,
        RD_BURST
    } avl_state_e;

endpackage

// File: rtl/mcpu_avl_bram_stub_if.sv
// Avalon-MM port 0 bundle between the core's ltc2mc master and the
// on-chip memory stub.
interface mcpu_avl_bram_stub_if;
    import mcpu_avl_pkg::*;

    logic [AVL_ADDR_W-1:0] ltc2mc_avl_addr_0;
    logic [AVL_BE_W-1:0]   ltc2mc_avl_be_0;
    logic                  ltc2mc_avl_burstbegin_0;
    logic                  ltc2mc_avl_read_req_0;
    logic                  ltc2mc_avl_write_req_0;
    logic [AVL_SIZE_W-1:0] ltc2mc_avl_size_0;
    logic [AVL_DATA_W-1:0] ltc2mc_avl_wdata_0;
    logic                  ltc2mc_avl_ready_0;
    logic [AVL_DATA_W-1:0] ltc2mc_avl_rdata_0;
    logic                  ltc2mc_avl_rdata_valid_0;

    modport master (
        output ltc2mc_avl_addr_0,
        output ltc2mc_avl_be_0,
        output ltc2mc_avl_burstbegin_0,
        output ltc2mc_avl_read_req_0,
        output ltc2mc_avl_write_req_0,
        output ltc2mc_avl_size_0,
        output ltc2mc_avl_wdata_0,
        input  ltc2mc_avl_ready_0,
        input  ltc2mc_avl_rdata_0,
        input  ltc2mc_avl_rdata_valid_0
    );

    modport slave (
        input  ltc2mc_avl_addr_0,
        input  ltc2mc_avl_be_0,
        input  ltc2mc_avl_burstbegin_0,
        input  ltc2mc_avl_read_req_0,
        input  ltc2mc_avl_write_req_0,
        input  ltc2mc_avl_size_0,
        input  ltc2mc_avl_wdata_0,
        output ltc2mc_avl_ready_0,
        output ltc2mc_avl_rdata_0,
        output ltc2mc_avl_rdata_valid_0
    );

endinterface

// File: rtl/mcpu_avl_bram_ram.sv
// Simple-dual-port 128-bit RAM with byte write enables and a read
// path stretched to READ_LATENCY cycles by a valid/data pipeline.
module mcpu_avl_bram_ram
    import mcpu_avl_pkg::*;
#(
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clkrst_mem_clk,
    input  logic                  clkrst_mem_rst_n,
    input  logic [AVL_BE_W-1:0]   we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [AVL_DATA_W-1:0] wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [AVL_DATA_W-1:0] rdata,
    output logic                  rvalid
);

    logic [AVL_DATA_W-1:0] mem [2**DEPTH_LOG2];
    logic [READ_LATENCY-1:0] v;
    logic [AVL_DATA_W-1:0] d [READ_LATENCY];

    always_ff @(posedge clkrst_mem_clk) begin
        for (int b = 0; b < AVL_BE_W; b++) begin
            if (we[b]) begin
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Data stages only advance behind a valid bit, so the output
    // word holds between beats.
    always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
        if (!clkrst_mem_rst_n) begin
            v <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                d[i] <= '0;
            end
        end else begin
            v[0] <= re;
            if (re) begin
                d[0] <= mem[raddr];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                v[i] <= v[i-1];
                if (v[i-1]) begin
                    d[i] <= d[i-1];
                end
            end
        end
    end

    assign rdata  = d[READ_LATENCY-1];
    assign rvalid = v[READ_LATENCY-1];

endmodule

// File: rtl/mcpu_avl_bram_stub.sv
// On-chip stand-in for the LPDDR controller: zero-fills after reset,
// then serves single and burst Avalon-MM reads and writes.
module mcpu_avl_bram_stub
    import mcpu_avl_pkg::*;
#(
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                 clkrst_mem_clk,
    input  logic                 clkrst_mem_rst_n,
    mcpu_avl_bram_stub_if.slave  avl,
    output logic                 mc_ready
);

    localparam int AW = DEPTH_LOG2;
    localparam int SW = AVL_SIZE_W;

    avl_state_e state, state_n;

    logic [AW-1:0] init_ctr, init_ctr_n;
    logic [AW-1:0] base, base_n;
    logic [SW-1:0] len, len_n;
    logic [SW-1:0] idx, idx_n;
    logic [SW-1:0] iss, iss_n;
    logic [SW-1:0] ret, ret_n;
    logic [SW-1:0] blen;

    logic [AVL_BE_W-1:0]   ram_we;
    logic [AW-1:0]         ram_waddr;
    logic [AW-1:0]         ram_raddr;
    logic [AVL_DATA_W-1:0] ram_wdata;
    logic [AVL_DATA_W-1:0] ram_rdata;
    logic                  ram_re;
    logic                  ram_rvalid;

    logic unused_avl;
    assign unused_avl = ^{avl.ltc2mc_avl_burstbegin_0,
                          avl.ltc2mc_avl_addr_0[AVL_ADDR_W-1:AW]};

    assign blen = (avl.ltc2mc_avl_size_0 == '0) ? SW'(1)
                                                : avl.ltc2mc_avl_size_0;

    assign avl.ltc2mc_avl_ready_0 = (state == IDLE) || (state == WR_BURST);
    assign mc_ready = (state != INIT);
    assign avl.ltc2mc_avl_rdata_0 = ram_rdata;
    assign avl.ltc2mc_avl_rdata_valid_0 = ram_rvalid;
    assign ram_raddr = base + AW'(iss);

    always_comb begin
        state_n    = state;
        init_ctr_n = init_ctr;
        base_n     = base;
        len_n      = len;
        idx_n      = idx;
        iss_n      = iss;
        ret_n      = ret;
        ram_we     = '0;
        ram_waddr  = init_ctr;
        ram_wdata  = '0;
        ram_re     = 1'b0;
        unique case (state)
            INIT: begin
                ram_we     = '1;
                init_ctr_n = init_ctr + AW'(1);
                if (init_ctr == {AW{1'b1}}) begin
                    state_n = IDLE;
                end
            end
            IDLE: begin
                if (avl.ltc2mc_avl_write_req_0) begin
                    ram_we    = avl.ltc2mc_avl_be_0;
                    ram_waddr = avl.ltc2mc_avl_addr_0[AW-1:0];
                    ram_wdata = avl.ltc2mc_avl_wdata_0;
                    base_n    = avl.ltc2mc_avl_addr_0[AW-1:0];
                    len_n     = blen;
                    idx_n     = SW'(1);
                    if (blen != SW'(1)) begin
                        state_n = WR_BURST;
                    end
                end else if (avl.ltc2mc_avl_read_req_0) begin
                    base_n  = avl.ltc2mc_avl_addr_0[AW-1:0];
                    len_n   = blen;
                    iss_n   = '0;
                    ret_n   = '0;
                    state_n = RD_BURST;
                end
            end
            WR_BURST: begin
                if (avl.ltc2mc_avl_write_req_0) begin
                    ram_we    = avl.ltc2mc_avl_be_0;
                    ram_waddr = base + AW'(idx);
                    ram_wdata = avl.ltc2mc_avl_wdata_0;
                    idx_n     = idx + SW'(1);
                    if (idx == len - SW'(1)) begin
                        state_n = IDLE;
                    end
                end
            end
            RD_BURST: begin
                if (iss < len) begin
                    ram_re = 1'b1;
                    iss_n  = iss + SW'(1);
                end
                // Stay busy until the final beat is on the bus.
                if (ram_rvalid) begin
                    ret_n = ret + SW'(1);
                    if (ret == len - SW'(1)) begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = INIT;
        endcase
    end

    always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
        if (!clkrst_mem_rst_n) begin
            state    <= INIT;
            init_ctr <= '0;
            base     <= '0;
            len      <= '0;
            idx      <= '0;
            iss      <= '0;
            ret      <= '0;
        end else begin
            state    <= state_n;
            init_ctr <= init_ctr_n;
            base     <= base_n;
            len      <= len_n;
            idx      <= idx_n;
            iss      <= iss_n;
            ret      <= ret_n;
        end
    end

    always @(posedge clkrst_mem_clk) begin
        if (clkrst_mem_rst_n && state == IDLE) begin
            assert (!(avl.ltc2mc_avl_write_req_0 &&
                      avl.ltc2mc_avl_read_req_0))
            else $warning("read and write requested together; read dropped");
        end
    end

    mcpu_avl_bram_ram #(
        .DEPTH_LOG2   (DEPTH_LOG2),
        .READ_LATENCY (READ_LATENCY)
    ) u_ram (
        .clkrst_mem_clk   (clkrst_mem_clk),
        .clkrst_mem_rst_n (clkrst_mem_rst_n),
        .we               (ram_we),
        .waddr            (ram_waddr),
        .wdata            (ram_wdata),
        .re               (ram_re),
        .raddr            (ram_raddr),
        .rdata            (ram_rdata),
        .rvalid           (ram_rvalid)
    );

endmodule

// File: tb/tb_mcpu_avl_bram_stub.sv
// Directed self-checking bench for the Avalon-MM BRAM stub.
module tb_mcpu_avl_bram_stub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mc_ready;

    mcpu_avl_bram_stub_if avl();

    mcpu_avl_bram_stub #(
        .DEPTH_LOG2   (10),
        .READ_LATENCY (2)
    ) dut (
        .clkrst_mem_clk   (clk),
        .clkrst_mem_rst_n (rst_n),
        .avl              (avl),
        .mc_ready         (mc_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [127:0] rd_q [32];
    int rd_cyc [32];
    int got;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input string tag);
        logic early;
        early = 1'b0;
        for (int e = 1; e <= 1023; e++) begin
            step();
            if (mc_ready !== 1'b0 || avl.ltc2mc_avl_ready_0 !== 1'b0 ||
                avl.ltc2mc_avl_rdata_valid_0 !== 1'b0)
                early = 1'b1;
        end
        chk({tag, "_early"}, 128'(early), 128'd0);
        step();
        chk({tag, "_mc_ready"}, 128'(mc_ready), 128'd1);
        chk({tag, "_ready"}, 128'(avl.ltc2mc_avl_ready_0), 128'd1);
    endtask

    task automatic wr(input logic [24:0] a, input logic [15:0] be,
                      input logic [127:0] d, input logic [4:0] sz);
        avl.ltc2mc_avl_addr_0 = a;
        avl.ltc2mc_avl_be_0 = be;
        avl.ltc2mc_avl_wdata_0 = d;
        avl.ltc2mc_avl_size_0 = sz;
        avl.ltc2mc_avl_burstbegin_0 = 1'b1;
        avl.ltc2mc_avl_write_req_0 = 1'b1;
        step();
        avl.ltc2mc_avl_write_req_0 = 1'b0;
        avl.ltc2mc_avl_burstbegin_0 = 1'b0;
    endtask

    task automatic rd(input logic [24:0] a, input logic [4:0] sz,
                      input int n, input string tag);
        int cyc;
        logic rdy_bad;
        logic gap_bad;
        for (int k = 0; k < 32; k++) rd_cyc[k] = -1;
        avl.ltc2mc_avl_addr_0 = a;
        avl.ltc2mc_avl_size_0 = sz;
        avl.ltc2mc_avl_read_req_0 = 1'b1;
        step();
        avl.ltc2mc_avl_read_req_0 = 1'b0;
        got = 0;
        cyc = 1;
        rdy_bad = 1'b0;
        while (cyc <= 60 && got < n) begin
            if (avl.ltc2mc_avl_rdata_valid_0) begin
                rd_q[got] = avl.ltc2mc_avl_rdata_0;
                rd_cyc[got] = cyc;
                got++;
            end
            if (avl.ltc2mc_avl_ready_0 !== 1'b0) rdy_bad = 1'b1;
            step();
            cyc++;
        end
        gap_bad = 1'b0;
        for (int k = 0; k < n; k++)
            if (rd_cyc[k] != 3 + k) gap_bad = 1'b1;
        chk({tag, "_beats"}, 128'(got), 128'(n));
        chk({tag, "_latency"}, 128'(rd_cyc[0]), 128'd3);
        chk({tag, "_contig"}, 128'(gap_bad), 128'd0);
        chk({tag, "_busy"}, 128'(rdy_bad), 128'd0);
        chk({tag, "_ready_after"}, 128'(avl.ltc2mc_avl_ready_0), 128'd1);
        chk({tag, "_no_extra"}, 128'(avl.ltc2mc_avl_rdata_valid_0), 128'd0);
    endtask

    initial begin
        logic flag;
        int t;
        avl.ltc2mc_avl_addr_0 = '0;
        avl.ltc2mc_avl_be_0 = '0;
        avl.ltc2mc_avl_burstbegin_0 = 1'b0;
        avl.ltc2mc_avl_read_req_0 = 1'b0;
        avl.ltc2mc_avl_write_req_0 = 1'b0;
        avl.ltc2mc_avl_size_0 = '0;
        avl.ltc2mc_avl_wdata_0 = '0;

        repeat (3) step();
        chk("rst_ready", 128'(avl.ltc2mc_avl_ready_0), 128'd0);
        chk("rst_mc_ready", 128'(mc_ready), 128'd0);
        chk("rst_rvalid", 128'(avl.ltc2mc_avl_rdata_valid_0), 128'd0);
        chk("rst_rdata", avl.ltc2mc_avl_rdata_0, 128'd0);

        avl.ltc2mc_avl_read_req_0 = 1'b1;
        rst_n = 1'b1;
        #1;
        avl.ltc2mc_avl_read_req_0 = 1'b0;
        wait_init("init");

        rd(25'h3FF, 5'd1, 1, "rd3ff");
        chk("rd3ff_data", rd_q[0], 128'd0);

        wr(25'h5, 16'h00FF, {16{8'hAA}}, 5'd1);
        rd(25'h5, 5'd1, 1, "rd5");
        chk("rd5_data", rd_q[0], {64'h0, {8{8'hAA}}});

        avl.ltc2mc_avl_addr_0 = 25'h3FE;
        avl.ltc2mc_avl_size_0 = 5'd4;
        avl.ltc2mc_avl_be_0 = 16'hFFFF;
        avl.ltc2mc_avl_wdata_0 = 128'd1;
        avl.ltc2mc_avl_write_req_0 = 1'b1;
        step();
        flag = ~avl.ltc2mc_avl_ready_0;
        avl.ltc2mc_avl_addr_0 = 25'h123;
        avl.ltc2mc_avl_size_0 = 5'd7;
        avl.ltc2mc_avl_read_req_0 = 1'b1;
        avl.ltc2mc_avl_wdata_0 = 128'd2;
        step();
        flag |= ~avl.ltc2mc_avl_ready_0;
        avl.ltc2mc_avl_write_req_0 = 1'b0;
        step();
        flag |= ~avl.ltc2mc_avl_ready_0;
        avl.ltc2mc_avl_read_req_0 = 1'b0;
        avl.ltc2mc_avl_write_req_0 = 1'b1;
        avl.ltc2mc_avl_wdata_0 = 128'd3;
        step();
        flag |= ~avl.ltc2mc_avl_ready_0;
        avl.ltc2mc_avl_wdata_0 = 128'd4;
        step();
        flag |= ~avl.ltc2mc_avl_ready_0;
        avl.ltc2mc_avl_write_req_0 = 1'b0;
        chk("wburst_ready", 128'(flag), 128'd0);
        chk("wburst_no_rvalid", 128'(avl.ltc2mc_avl_rdata_valid_0), 128'd0);

        rd(25'h3FE, 5'd4, 4, "rburst");
        chk("rburst_b0", rd_q[0], 128'd1);
        chk("rburst_b1", rd_q[1], 128'd2);
        chk("rburst_b2", rd_q[2], 128'd3);
        chk("rburst_b3", rd_q[3], 128'd4);
        step();
        step();
        chk("rdata_hold", avl.ltc2mc_avl_rdata_0, 128'd4);

        rd(25'h1000001, 5'd0, 1, "alias_sz0");
        chk("alias_sz0_data", rd_q[0], 128'd4);

        avl.ltc2mc_avl_addr_0 = 25'h10;
        avl.ltc2mc_avl_size_0 = 5'd1;
        avl.ltc2mc_avl_be_0 = 16'hFFFF;
        avl.ltc2mc_avl_wdata_0 = {16{8'h55}};
        avl.ltc2mc_avl_write_req_0 = 1'b1;
        avl.ltc2mc_avl_read_req_0 = 1'b1;
        step();
        avl.ltc2mc_avl_write_req_0 = 1'b0;
        avl.ltc2mc_avl_read_req_0 = 1'b0;
        flag = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (avl.ltc2mc_avl_rdata_valid_0 !== 1'b0 ||
                avl.ltc2mc_avl_ready_0 !== 1'b1)
                flag = 1'b1;
            step();
        end
        chk("both_req_no_read", 128'(flag), 128'd0);
        rd(25'h10, 5'd1, 1, "both_req_rd");
        chk("both_req_data", rd_q[0], {16{8'h55}});

        avl.ltc2mc_avl_addr_0 = 25'h3FE;
        avl.ltc2mc_avl_size_0 = 5'd8;
        avl.ltc2mc_avl_read_req_0 = 1'b1;
        step();
        avl.ltc2mc_avl_read_req_0 = 1'b0;
        t = 0;
        while (t < 20 && avl.ltc2mc_avl_rdata_valid_0 !== 1'b1) begin
            step();
            t++;
        end
        chk("mid_b0_seen", 128'(avl.ltc2mc_avl_rdata_valid_0), 128'd1);
        step();
        chk("mid_b1_valid", 128'(avl.ltc2mc_avl_rdata_valid_0), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", 128'(avl.ltc2mc_avl_rdata_valid_0), 128'd0);
        chk("mid_rst_mc_ready", 128'(mc_ready), 128'd0);
        chk("mid_rst_ready", 128'(avl.ltc2mc_avl_ready_0), 128'd0);
        flag = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (avl.ltc2mc_avl_rdata_valid_0 !== 1'b0) flag = 1'b1;
        end
        chk("mid_rst_hold", 128'(flag), 128'd0);
        rst_n = 1'b1;
        wait_init("reinit");

        rd(25'h3FE, 5'd2, 2, "rz_3fe");
        chk("rz_3fe_b0", rd_q[0], 128'd0);
        chk("rz_3fe_b1", rd_q[1], 128'd0);
        rd(25'h5, 5'd1, 1, "rz_5");
        chk("rz_5_data", rd_q[0], 128'd0);
        rd(25'h10, 5'd1, 1, "rz_10");
        chk("rz_10_data", rd_q[0], 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
